// File: rtl/bram_port_arbiter.sv
// ----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one synchronous block-RAM port between two requesters. After reset
// the block walks every address and writes zero (INIT). It then arbitrates
// read/write requests round-robin (RUN). Accepted requests reach the memory
// port in the same cycle. Read data returns two cycles later to the requester
// that issued the read.
//
// Ports
//   clka                 clock, rising edge
//   rstb                 synchronous, active-high reset
//   rN_req_val/wr/addr/wdata  request from requester N (N = 0, 1)
//   rN_req_rdy           request accepted this cycle (combinational grant)
//   rN_resp_val/data     read response for requester N
//   mem_en/we/addr/din   memory port controls and write data
//   mem_regce, mem_rst   memory output-register enable and output reset
//   mem_dout             memory read data (2-cycle latency, write-first)
//   init_done            clear complete, requests are being accepted
// ----------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 18
) (
    input  logic              clka,
    input  logic              rstb,

    input  logic              r0_req_val,
    input  logic              r0_req_wr,
    input  logic [ADDR_W-1:0] r0_req_addr,
    input  logic [DATA_W-1:0] r0_req_wdata,
    output logic              r0_req_rdy,
    output logic              r0_resp_val,
    output logic [DATA_W-1:0] r0_resp_data,

    input  logic              r1_req_val,
    input  logic              r1_req_wr,
    input  logic [ADDR_W-1:0] r1_req_addr,
    input  logic [DATA_W-1:0] r1_req_wdata,
    output logic              r1_req_rdy,
    output logic              r1_resp_val,
    output logic [DATA_W-1:0] r1_resp_data,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_regce,
    output logic              mem_rst,
    input  logic [DATA_W-1:0] mem_dout,

    output logic              init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              last_grant;  // id of the most recently granted requester
    logic [1:0]        pipe_val;    // [0] = read issued last cycle, [1] = two cycles ago
    logic [1:0]        pipe_id;

    logic grant0;
    logic grant1;
    logic accept;
    logic accept_wr;

    // Round-robin grant. A tie goes to the requester that was not granted
    // last. No grant is given while reset is asserted, so nothing is issued
    // to the memory during that cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_RUN && !rstb) begin
            if (r0_req_val && (!r1_req_val || last_grant))
                grant0 = 1'b1;
            else if (r1_req_val)
                grant1 = 1'b1;
        end
    end

    assign accept    = grant0 | grant1;
    assign accept_wr = grant1 ? r1_req_wr : r0_req_wr;

    assign r0_req_rdy = grant0;
    assign r1_req_rdy = grant1;

    // Memory port mux: reset holds the port idle, INIT writes zeros, and RUN
    // forwards the granted request in the cycle it is accepted.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (rstb) begin
            mem_en = 1'b0;
        end else if (state == ST_INIT) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = init_cnt;
        end else if (grant0) begin
            mem_en   = 1'b1;
            mem_we   = r0_req_wr;
            mem_addr = r0_req_addr;
            mem_din  = r0_req_wdata;
        end else if (grant1) begin
            mem_en   = 1'b1;
            mem_we   = r1_req_wr;
            mem_addr = r1_req_addr;
            mem_din  = r1_req_wdata;
        end
    end

    assign mem_regce = 1'b1;
    assign mem_rst   = rstb;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clka) begin
        if (rstb) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            last_grant <= 1'b1;
            pipe_val   <= '0;
            pipe_id    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    // Stop on the last address instead of wrapping; the
                    // counter is only reused after the next reset.
                    if (init_cnt == LAST_ADDR)
                        state <= ST_RUN;
                    else
                        init_cnt <= init_cnt + ADDR_W'(1);
                end
                ST_RUN: begin
                    if (accept)
                        last_grant <= grant1;
                end
                default: state <= ST_INIT;
            endcase
            // The owner of each read travels alongside the 2-cycle memory latency.
            pipe_val <= {pipe_val[0], accept && !accept_wr};
            pipe_id  <= {pipe_id[0], grant1};
        end
    end

    assign r0_resp_val  = pipe_val[1] && !pipe_id[1];
    assign r1_resp_val  = pipe_val[1] &&  pipe_id[1];
    assign r0_resp_data = mem_dout;
    assign r1_resp_data = mem_dout;

    assign init_done = (state == ST_RUN);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Directed bench for bram_port_arbiter with ADDR_W=4. A behavioural model
// stands in for the block RAM: 2-cycle read latency, write-first, with its
// output registers cleared by mem_rst. Inputs change 1 time unit after each
// rising edge. Outputs are checked 1 time unit later.
// ----------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 18;

    logic              clka;
    logic              rstb;
    logic              r0_req_val, r0_req_wr, r0_req_rdy, r0_resp_val;
    logic [ADDR_W-1:0] r0_req_addr;
    logic [DATA_W-1:0] r0_req_wdata, r0_resp_data;
    logic              r1_req_val, r1_req_wr, r1_req_rdy, r1_resp_val;
    logic [ADDR_W-1:0] r1_req_addr;
    logic [DATA_W-1:0] r1_req_wdata, r1_resp_data;
    logic              mem_en, mem_we, mem_regce, mem_rst;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din, mem_dout;
    logic              init_done;

    int errors = 0;
    int checks = 0;

    bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clka         (clka),
        .rstb         (rstb),
        .r0_req_val   (r0_req_val),
        .r0_req_wr    (r0_req_wr),
        .r0_req_addr  (r0_req_addr),
        .r0_req_wdata (r0_req_wdata),
        .r0_req_rdy   (r0_req_rdy),
        .r0_resp_val  (r0_resp_val),
        .r0_resp_data (r0_resp_data),
        .r1_req_val   (r1_req_val),
        .r1_req_wr    (r1_req_wr),
        .r1_req_addr  (r1_req_addr),
        .r1_req_wdata (r1_req_wdata),
        .r1_req_rdy   (r1_req_rdy),
        .r1_resp_val  (r1_resp_val),
        .r1_resp_data (r1_resp_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_regce    (mem_regce),
        .mem_rst      (mem_rst),
        .mem_dout     (mem_dout),
        .init_done    (init_done)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Block-RAM model. The array starts as all ones so that a skipped clear is visible.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] dout_q1;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '1;
        dout_q1  = '0;
        mem_dout = '0;
    end

    always @(posedge clka) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_din;
                dout_q1       <= mem_din;
            end else begin
                dout_q1       <= mem[mem_addr];
            end
        end
        if (mem_rst)        mem_dout <= '0;
        else if (mem_regce) mem_dout <= dout_q1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        r0_req_val = 1'b0; r0_req_wr = 1'b0; r0_req_addr = '0; r0_req_wdata = '0;
        r1_req_val = 1'b0; r1_req_wr = 1'b0; r1_req_addr = '0; r1_req_wdata = '0;
    endtask

    initial begin
        rstb = 1'b1;
        idle_inputs();

        // ---------------- reset ----------------
        tick(); tick();
        settle();
        check("rst_mem_en",    32'(mem_en), 0);
        check("rst_mem_we",    32'(mem_we), 0);
        check("rst_mem_rst",   32'(mem_rst), 1);
        check("rst_regce",     32'(mem_regce), 1);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_resp_val",  32'({r0_resp_val, r1_resp_val}), 0);

        // ---------------- clear after reset ----------------
        // A read is held pending through INIT. It must not be accepted until RUN.
        tick();
        rstb        = 1'b0;
        r0_req_val  = 1'b1;
        r0_req_addr = 4'd5;
        settle();
        for (int i = 0; i < 16; i++) begin
            check("init_we",   32'(mem_we), 1);
            check("init_addr", 32'(mem_addr), 32'(i));
            check("init_din",  32'(mem_din), 0);
            check("init_rdy",  32'({r0_req_rdy, r1_req_rdy}), 0);
            check("init_done_lo", 32'(init_done), 0);
            tick();
        end
        // First RUN cycle: the pending read is accepted.
        check("run_init_done", 32'(init_done), 1);
        check("run_rd_rdy0",   32'(r0_req_rdy), 1);
        check("run_rd_we",     32'(mem_we), 0);
        check("run_rd_addr",   32'(mem_addr), 5);
        tick();
        r0_req_val = 1'b0;
        settle();
        check("idle_mem_en",   32'(mem_en), 0);
        check("idle_rdy",      32'({r0_req_rdy, r1_req_rdy}), 0);
        check("idle_resp",     32'({r0_resp_val, r1_resp_val}), 0);
        tick();
        check("clr_resp_val0", 32'(r0_resp_val), 1);
        check("clr_resp_val1", 32'(r1_resp_val), 0);
        check("clr_resp_data", 32'(r0_resp_data), 0);

        // ---------------- read after write ----------------
        r0_req_val = 1'b1; r0_req_wr = 1'b1; r0_req_addr = 4'd3; r0_req_wdata = 18'h2A;
        settle();
        check("raw_wr_rdy0", 32'(r0_req_rdy), 1);
        check("raw_wr_we",   32'(mem_we), 1);
        check("raw_wr_addr", 32'(mem_addr), 3);
        check("raw_wr_din",  32'(mem_din), 32'h2A);
        tick();
        r0_req_val = 1'b0; r0_req_wr = 1'b0;
        r1_req_val = 1'b1; r1_req_wr = 1'b0; r1_req_addr = 4'd3;
        settle();
        check("raw_rd_rdy", 32'({r0_req_rdy, r1_req_rdy}), 32'b01);
        check("raw_rd_we",  32'(mem_we), 0);
        tick();
        r1_req_val = 1'b0;
        settle();
        check("raw_no_wr_resp", 32'({r0_resp_val, r1_resp_val}), 0);
        tick();
        check("raw_resp_val", 32'({r0_resp_val, r1_resp_val}), 32'b01);
        check("raw_resp_dat", 32'(r1_resp_data), 32'h2A);

        // ---------------- preload addresses 8..13 via r1 ----------------
        for (int i = 8; i < 14; i++) begin
            r1_req_val = 1'b1; r1_req_wr = 1'b1;
            r1_req_addr = ADDR_W'(i); r1_req_wdata = DATA_W'(32'h100 + i);
            settle();
            check("pre_wr_rdy1", 32'(r1_req_rdy), 1);
            tick();
        end
        r1_req_val = 1'b0; r1_req_wr = 1'b0;

        // ---------------- both requesters reading: alternation ----------------
        // r1 was granted last, so r0 goes first. r0 reads 8,10,12 and r1 reads 9,11,13.
        for (int i = 0; i < 8; i++) begin
            r0_req_val  = (i < 6);
            r1_req_val  = (i < 6);
            r0_req_addr = ADDR_W'(8 + 2 * ((i + 1) / 2));
            r1_req_addr = ADDR_W'(9 + 2 * (i / 2));
            settle();
            if (i < 6) begin
                check("alt_rdy0", 32'(r0_req_rdy), 32'((i % 2) == 0));
                check("alt_rdy1", 32'(r1_req_rdy), 32'((i % 2) == 1));
                check("alt_addr", 32'(mem_addr), 32'(8 + i));
            end
            if (i >= 2) begin
                check("alt_resp0", 32'(r0_resp_val), 32'((i % 2) == 0));
                check("alt_resp1", 32'(r1_resp_val), 32'((i % 2) == 1));
                check("alt_rdata", 32'((i % 2) == 0 ? r0_resp_data : r1_resp_data), 32'h100 + 32'(8 + i - 2));
            end
            tick();
        end
        idle_inputs();

        // ---------------- lone r1, then a tie ----------------
        r1_req_val = 1'b1; r1_req_addr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("lone_rdy1", 32'({r0_req_rdy, r1_req_rdy}), 32'b01);
            tick();
        end
        r0_req_val = 1'b1; r0_req_addr = 4'd0;
        settle();
        check("tie_after_r1", 32'({r0_req_rdy, r1_req_rdy}), 32'b10);
        tick();
        r0_req_val = 1'b0;
        settle();
        check("tie_then_r1", 32'({r0_req_rdy, r1_req_rdy}), 32'b01);
        tick();
        r1_req_val = 1'b0;
        tick(); tick();
        check("drain_idle_en", 32'(mem_en), 0);
        check("drain_idle_rs", 32'({r0_resp_val, r1_resp_val}), 0);

        // ---------------- reset during RUN discards reads in flight ----------------
        r0_req_val = 1'b1; r0_req_addr = 4'd8;
        settle();
        check("flush_acc0", 32'(r0_req_rdy), 1);
        tick();
        r0_req_val = 1'b0;
        rstb       = 1'b1;
        r1_req_val = 1'b1; r1_req_addr = 4'd9;
        settle();
        check("flush_rst_rdy", 32'({r0_req_rdy, r1_req_rdy}), 0);
        check("flush_rst_en",  32'(mem_en), 0);
        tick();
        rstb       = 1'b0;
        r1_req_val = 1'b0;
        settle();
        check("flush_t2_resp", 32'({r0_resp_val, r1_resp_val}), 0);
        check("flush_t2_done", 32'(init_done), 0);
        check("flush_t2_addr", 32'(mem_addr), 0);
        tick();
        check("flush_t3_resp", 32'({r0_resp_val, r1_resp_val}), 0);
        check("flush_t3_addr", 32'(mem_addr), 1);
        tick();
        // ---------------- reset during INIT restarts the clear ----------------
        check("mid_init_addr2", 32'(mem_addr), 2);
        rstb = 1'b1;
        tick();
        rstb = 1'b0;
        settle();
        for (int i = 0; i < 16; i++) begin
            check("reinit_addr", 32'(mem_addr), 32'(i));
            check("reinit_done", 32'(init_done), 0);
            tick();
        end
        check("reinit_done_hi", 32'(init_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time so the bench always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish within limit");
        $fatal(1, "timeout");
    end

endmodule
